// File: rtl/fp32_pkg.sv
// Shared types and constants for the single-precision divider.
package fp32_pkg;

  localparam int unsigned BIAS      = 127;
  localparam int unsigned EXP_MAX   = 254;
  localparam int unsigned DIV_ITERS = 26;
  localparam int unsigned EXP_W     = 10;
  localparam int unsigned SIG_W     = 24;
  localparam int unsigned Q_W       = 26;
  localparam int unsigned ITER_W    = 5;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;

  typedef enum logic [2:0] {
    IDLE,
    UNPACK,
    DIVIDE,
    NORM,
    ROUND,
    DONE
  } state_t;

  typedef struct packed {
    logic nan;
    logic inf;
    logic ovf;
    logic unf;
    logic dz;
  } flags_t;

  typedef logic signed [EXP_W-1:0] exp_t;

endpackage

// File: rtl/fp32_classify.sv
// Combinational operand classifier: zero, infinity, NaN and subnormal detection.
module fp32_classify
  import fp32_pkg::*;
(
  input  logic [7:0]  i_exp,
  input  logic [22:0] i_frac,
  output logic        o_is_zero,
  output logic        o_is_inf,
  output logic        o_is_nan,
  output logic        o_is_subnormal
);

  logic w_exp_min;
  logic w_exp_max;
  logic w_frac_nz;

  assign w_exp_min = (i_exp == 8'h00);
  assign w_exp_max = (i_exp == 8'hFF);
  assign w_frac_nz = (i_frac != 23'd0);

  assign o_is_zero      = w_exp_min & ~w_frac_nz;
  assign o_is_subnormal = w_exp_min &  w_frac_nz;
  assign o_is_inf       = w_exp_max & ~w_frac_nz;
  assign o_is_nan       = w_exp_max &  w_frac_nz;

endmodule

// File: rtl/divider32_fp.sv
// Multi-cycle IEEE-754 single-precision divider (restoring, one quotient bit per cycle).
// Define FP_DIV_ROUND_NEAREST_EN for round-to-nearest-even; default build truncates.
module divider32_fp
  import fp32_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] quotient_o,
  output logic        done_o,
  output logic        busy_o,
  output logic        nan_o,
  output logic        infinit_o,
  output logic        overflow_o,
  output logic        underflow_o,
  output logic        dz_o
);

`ifdef FP_DIV_ROUND_NEAREST_EN
  localparam logic RNE_EN = 1'b1;
`else
  localparam logic RNE_EN = 1'b0;
`endif

  localparam exp_t        EXP_BIAS_S = exp_t'(BIAS);
  localparam exp_t        EXP_MAX_S  = exp_t'(EXP_MAX);
  localparam exp_t        EXP_ONE_S  = exp_t'(1);
  localparam logic [30:0] INF_MAG    = POS_INF[30:0];

  state_t              r_state;
  fp32_t               r_a;
  fp32_t               r_b;
  logic                r_sign;
  exp_t                r_exp;
  logic [SIG_W-1:0]    r_divisor;
  logic [Q_W-1:0]      r_rem;
  logic [Q_W-1:0]      r_q;
  logic [ITER_W-1:0]   r_iter;
  logic [SIG_W-1:0]    r_sig;
  logic                r_guard;
  logic                r_sticky;
  logic [31:0]         r_quot;
  flags_t              r_flags;
  logic                r_done;
  logic                r_busy;

  logic w_a_zero, w_a_inf, w_a_nan, w_a_sub;
  logic w_b_zero, w_b_inf, w_b_nan, w_b_sub;
  logic w_a_z, w_b_z, w_sign;

  fp32_classify u_cls_a (
    .i_exp          (r_a.exp),
    .i_frac         (r_a.frac),
    .o_is_zero      (w_a_zero),
    .o_is_inf       (w_a_inf),
    .o_is_nan       (w_a_nan),
    .o_is_subnormal (w_a_sub)
  );

  fp32_classify u_cls_b (
    .i_exp          (r_b.exp),
    .i_frac         (r_b.frac),
    .o_is_zero      (w_b_zero),
    .o_is_inf       (w_b_inf),
    .o_is_nan       (w_b_nan),
    .o_is_subnormal (w_b_sub)
  );

  // Subnormals are flushed: they behave exactly like signed zero.
  assign w_a_z  = w_a_zero | w_a_sub;
  assign w_b_z  = w_b_zero | w_b_sub;
  assign w_sign = r_a.sign ^ r_b.sign;

  logic        w_special;
  logic [31:0] w_spec_q;
  flags_t      w_spec_flags;

  // Special-operand resolution; priority order matters (NaN cases first).
  always_comb begin
    w_special        = 1'b1;
    w_spec_q         = QNAN;
    w_spec_flags     = '0;
    w_spec_flags.inf = w_a_inf | w_b_inf;
    if (w_a_nan | w_b_nan | (w_a_z & w_b_z) | (w_a_inf & w_b_inf)) begin
      w_spec_q         = QNAN;
      w_spec_flags.nan = 1'b1;
    end else if (w_a_inf) begin
      w_spec_q = {w_sign, INF_MAG};
    end else if (w_b_inf) begin
      w_spec_q = {w_sign, 31'd0};
    end else if (w_b_z) begin
      w_spec_q        = {w_sign, INF_MAG};
      w_spec_flags.dz = 1'b1;
    end else if (w_a_z) begin
      w_spec_q = {w_sign, 31'd0};
    end else begin
      w_special = 1'b0;
    end
  end

  exp_t w_exp_diff;
  assign w_exp_diff = exp_t'({2'b00, r_a.exp}) - exp_t'({2'b00, r_b.exp}) + EXP_BIAS_S;

  logic                w_rem_ge;
  logic [Q_W-2:0]      w_rem_sub;
  logic [Q_W-1:0]      w_rem_next;

  // One restoring step: subtract when possible, then shift the partial remainder.
  assign w_rem_ge   = (r_rem >= {2'b00, r_divisor});
  assign w_rem_sub  = w_rem_ge ? (Q_W-1)'(r_rem - {2'b00, r_divisor}) : r_rem[Q_W-2:0];
  assign w_rem_next = {w_rem_sub, 1'b0};

  logic           w_inc;
  logic [SIG_W:0] w_sig_rnd;
  logic [22:0]    w_frac_fin;
  exp_t           w_exp_fin;
  logic           w_ovf;
  logic           w_unf;

  assign w_inc      = RNE_EN & r_guard & (r_sticky | r_sig[0]);
  assign w_sig_rnd  = {1'b0, r_sig} + (SIG_W+1)'(w_inc);
  assign w_frac_fin = w_sig_rnd[SIG_W] ? w_sig_rnd[23:1] : w_sig_rnd[22:0];
  assign w_exp_fin  = w_sig_rnd[SIG_W] ? (r_exp + EXP_ONE_S) : r_exp;
  assign w_ovf      = (w_exp_fin > EXP_MAX_S);
  assign w_unf      = (w_exp_fin < EXP_ONE_S);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_sign    <= 1'b0;
      r_exp     <= '0;
      r_divisor <= '0;
      r_rem     <= '0;
      r_q       <= '0;
      r_iter    <= '0;
      r_sig     <= '0;
      r_guard   <= 1'b0;
      r_sticky  <= 1'b0;
      r_quot    <= '0;
      r_flags   <= '0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start_i) begin
            r_a     <= a_i;
            r_b     <= b_i;
            r_flags <= '0;
            r_busy  <= 1'b1;
            r_state <= UNPACK;
          end
        end
        UNPACK: begin
          r_sign <= w_sign;
          r_exp  <= w_exp_diff;
          if (w_special) begin
            r_quot  <= w_spec_q;
            r_flags <= w_spec_flags;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_rem     <= {2'b01, r_a.frac};
            r_divisor <= {1'b1, r_b.frac};
            r_q       <= '0;
            r_iter    <= '0;
            r_state   <= DIVIDE;
          end
        end
        DIVIDE: begin
          r_q    <= {r_q[Q_W-2:0], w_rem_ge};
          r_rem  <= w_rem_next;
          r_iter <= r_iter + ITER_W'(1);
          if (r_iter == ITER_W'(DIV_ITERS - 1)) begin
            r_state <= NORM;
          end
        end
        NORM: begin
          // Quotient lies in [0.5, 2); align the leading one to sig[23].
          if (r_q[Q_W-1]) begin
            r_sig    <= r_q[25:2];
            r_guard  <= r_q[1];
            r_sticky <= r_q[0] | (r_rem != '0);
          end else begin
            r_sig    <= r_q[24:1];
            r_guard  <= r_q[0];
            r_sticky <= (r_rem != '0);
            r_exp    <= r_exp - EXP_ONE_S;
          end
          r_state <= ROUND;
        end
        ROUND: begin
          if (w_ovf) begin
            r_quot <= {r_sign, INF_MAG};
          end else if (w_unf) begin
            r_quot <= {r_sign, 31'd0};
          end else begin
            r_quot <= {r_sign, w_exp_fin[7:0], w_frac_fin};
          end
          r_flags.ovf <= w_ovf;
          r_flags.unf <= w_unf & ~w_ovf;
          r_done      <= 1'b1;
          r_state     <= DONE;
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign quotient_o  = r_quot;
  assign done_o      = r_done;
  assign busy_o      = r_busy;
  assign nan_o       = r_flags.nan;
  assign infinit_o   = r_flags.inf;
  assign overflow_o  = r_flags.ovf;
  assign underflow_o = r_flags.unf;
  assign dz_o        = r_flags.dz;

endmodule
